iob_eth_tx_sched: RTL and testbench
===================================

// Module: iob_eth_tx_sched
// PURPOSE
// - Shares the single MII transmit engine among NREQ frame sources (e.g. CPU buffer, pause-frame generator).
// - Validates each frame's length, runs the engine's send/ready handshake, and steers its buffer-read mux via sel_o.
// - Enforces the Ethernet inter-frame gap (IFG) between frames.
// - Sits between the TX buffers/requesters and the transmit engine, in the TX clock domain.
// PARAMETERS
// - NREQ        2     number of requesters (1..8)
// - IFG_CYCLES  24    idle tx_clk cycles after each frame (96 bit times at 4 bits/cycle)
// - MIN_NBYTES  72    smallest legal nbytes (preamble+SFD+64-byte min frame)
// - MAX_NBYTES  1526  largest legal nbytes (< 2048, fits 11 bits)
// PORTS
// - tx_clk_i      in   1        TX clock; all logic on its rising edge
// - tx_arst_n_i   in   1        reset, asynchronous, active-low
// - req_i         in   NREQ     level request per source; held until done_o/err_o
// - nbytes_i      in   NREQ*11  packed lengths; slice i = nbytes_i[11*i+:11]
// - done_o        out  NREQ     1-cycle pulse: frame of source i fully sent
// - err_o         out  NREQ     1-cycle pulse: frame of source i rejected (length)
// - busy_o        out  1        high from grant until end of IFG
// - sel_o         out  SELW     granted source; SELW = max(1,$clog2(NREQ))
// - eng_nbytes_o  out  11       length driven to the engine
// - eng_send_o    out  1        send strobe to the engine
// - eng_ready_i   in   1        engine ready (low while transmitting)
// BEHAVIOUR
// - Reset values: all outputs 0. RR pointer = 0. FSM in IDLE.
// - Reset asserted mid-frame: everything returns to reset values immediately.
//   - The engine is reset by the same net.
// - FSM: IDLE -> ARB -> CHECK -> SEND -> WAIT_DONE -> IFG -> IDLE.
// - IDLE: on any req_i bit, pick a winner round-robin.
//   - Search starts at the RR pointer, upward, wrapping at NREQ-1 -> 0.
//   - Go to ARB.
// - ARB (1 cycle):
//   - Register sel_o = winner and eng_nbytes_o = nbytes_i slice; set busy_o = 1.
//   - RR pointer = winner+1 mod NREQ.
// - CHECK:
//   - If nbytes is outside [MIN_NBYTES, MAX_NBYTES]: pulse err_o[sel], busy_o = 0, back to IDLE (no IFG).
//   - Otherwise wait in CHECK until eng_ready_i = 1, then go to SEND.
// - SEND: eng_send_o = 1, held until eng_ready_i is sampled 0, then eng_send_o = 0 -> WAIT_DONE.
//   - The engine drops ready one cycle after sampling send.
//   - eng_send_o is therefore high exactly 1 cycle.
// - WAIT_DONE: wait for eng_ready_i = 1.
//   - That cycle: pulse done_o[sel], load the IFG counter = IFG_CYCLES-1, go to IFG.
// - IFG: decrement to 0, then busy_o = 0 -> IDLE. New arbitration happens in the next cycle.
// - sel_o and eng_nbytes_o stay stable from ARB through the end of IFG.
// - req_i or nbytes_i changing after ARB is ignored; the frame completes.
// - A req_i bit that falls before grant is simply not served. No latching of requests.
// - done_o and err_o are never both high, and at most one bit of each is set at a time.
// - Requester handshake: drop req_i on the done/err pulse cycle.
//   - A request still high the cycle after the pulse is treated as a new frame.
// CONFIGURATION
// - Macro IOB_ETH_TX_SCHED_PRIO_EN.
// - Defined: source 0 has strict priority. If req_i[0] is high in IDLE, it wins regardless of the RR pointer.
//   - The other sources rotate round-robin among themselves.
//   - The RR pointer updates only on grants to sources >= 1.
// - Undefined: pure round-robin over all NREQ sources.
// STRUCTURE
// - Shared package iob_eth_pkg:
//   - FSM state encoding (localparams IDLE..IFG, 3 bits).
//   - ETH_NBYTES_W = 11, default IFG/MIN/MAX constants.
// - Sub-module iob_eth_rr_arb (NREQ, req -> one-hot grant + index, pointer input).
//   - Contains the priority override under the macro.
// - Remainder (FSM, IFG counter, output registers) stays in this file.
// TESTING
// - NREQ=2; req_i=2'b01, nbytes0=100, engine model holds ready low 400 cycles.
//   - Expect: one eng_send_o pulse, eng_nbytes_o=100, sel_o=0.
//   - Expect: done_o=2'b01 the cycle ready rises, busy_o low 24 cycles later.
// - req_i=2'b11 held, both nbytes=80.
//   - Expect grants 0,1,0,1 (RR), each separated by >=24 idle cycles, one done_o pulse per frame.
// - nbytes1=50 (and separately 1600) with req_i[1].
//   - Expect err_o=2'b10 pulse 2 cycles after the request, no eng_send_o, busy_o back to 0, no IFG.
// - Engine ready=0 when a request arrives.
//   - Expect FSM waits in CHECK, no send until ready=1, then a single send pulse.
// - Reset (tx_arst_n_i=0) asserted during WAIT_DONE.
//   - Expect all outputs 0 asynchronously.
//   - Expect the next request after release granted to source 0 first.
// - With IOB_ETH_TX_SCHED_PRIO_EN, NREQ=3, req_i=3'b111 held.
//   - Expect grant order 0,0,0... until req_i[0] drops, then 1,2,1,2.

Source files
------------

// File: rtl/iob_eth_pkg.sv
// Shared constants, FSM encoding and small helpers for the Ethernet TX scheduler.
package iob_eth_pkg;

   localparam int ETH_NBYTES_W   = 11;
   localparam int ETH_IFG_CYCLES = 24;
   localparam int ETH_MIN_NBYTES = 72;
   localparam int ETH_MAX_NBYTES = 1526;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ARB       = 3'd1;
   localparam logic [2:0] ST_CHECK     = 3'd2;
   localparam logic [2:0] ST_SEND      = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;
   localparam logic [2:0] ST_IFG       = 3'd5;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      ARB       = ST_ARB,
      CHECK     = ST_CHECK,
      SEND      = ST_SEND,
      WAIT_DONE = ST_WAIT_DONE,
      IFG       = ST_IFG
   } state_t;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/iob_eth_tx_sched_if.sv
// Requester/engine side signals of the TX scheduler; master = requesters + engine, slave = scheduler.
interface iob_eth_tx_sched_if #(
   parameter int NREQ = 2
);
   localparam int SELW = iob_eth_pkg::sel_w(NREQ);
   localparam int NBW  = iob_eth_pkg::ETH_NBYTES_W;

   logic [NREQ-1:0]     req_i;
   logic [NREQ*NBW-1:0] nbytes_i;
   logic [NREQ-1:0]     done_o;
   logic [NREQ-1:0]     err_o;
   logic                busy_o;
   logic [SELW-1:0]     sel_o;
   logic [NBW-1:0]      eng_nbytes_o;
   logic                eng_send_o;
   logic                eng_ready_i;

   modport master (
      output req_i, nbytes_i, eng_ready_i,
      input  done_o, err_o, busy_o, sel_o, eng_nbytes_o, eng_send_o
   );

   modport slave (
      input  req_i, nbytes_i, eng_ready_i,
      output done_o, err_o, busy_o, sel_o, eng_nbytes_o, eng_send_o
   );

endinterface

// File: rtl/iob_eth_rr_arb.sv
// Round-robin arbiter: search starts at ptr and wraps. With IOB_ETH_TX_SCHED_PRIO_EN
// source 0 wins outright and the rotation covers sources 1..NREQ-1 only.
module iob_eth_rr_arb
   import iob_eth_pkg::*;
#(
   parameter  int NREQ = 2,
   localparam int SELW = sel_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [SELW-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [SELW-1:0] idx,
   output logic            any
);

   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] rot;
   int              sum;
   logic            found;

   always_comb begin
      cand = req;
`ifdef IOB_ETH_TX_SCHED_PRIO_EN
      cand[0] = 1'b0;
`endif
      // rotate so bit 0 is the source the pointer names; first set bit wins
      rot   = NREQ'({cand, cand} >> ptr);
      found = 1'b0;
      sum   = 0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            sum   = int'(ptr) + i;
         end
      end
      if (sum >= NREQ) sum = sum - NREQ;
      idx = SELW'(sum);
      any = found;
`ifdef IOB_ETH_TX_SCHED_PRIO_EN
      if (req[0]) begin
         idx = '0;
         any = 1'b1;
      end
`endif
      gnt = any ? (NREQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/iob_eth_tx_sched.sv
// Shares the MII TX engine among NREQ sources: arbitration, length check, send handshake, IFG.
// Optional macro IOB_ETH_TX_SCHED_PRIO_EN gives source 0 strict priority.
module iob_eth_tx_sched
   import iob_eth_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int IFG_CYCLES = ETH_IFG_CYCLES,
   parameter int MIN_NBYTES = ETH_MIN_NBYTES,
   parameter int MAX_NBYTES = ETH_MAX_NBYTES
) (
   input logic               tx_clk_i,
   input logic               tx_arst_n_i,
   iob_eth_tx_sched_if.slave bus
);

   localparam int SELW = sel_w(NREQ);
   localparam int CNTW = sel_w(IFG_CYCLES);
   localparam logic [ETH_NBYTES_W-1:0] MIN_L = ETH_NBYTES_W'(MIN_NBYTES);
   localparam logic [ETH_NBYTES_W-1:0] MAX_L = ETH_NBYTES_W'(MAX_NBYTES);

   state_t          state;
   logic [SELW-1:0] ptr;
   logic [SELW-1:0] arb_idx;
   logic [SELW-1:0] win_idx;
   logic [NREQ-1:0] arb_gnt;
   logic [NREQ-1:0] win_oh;
   logic            arb_any;
   logic [CNTW-1:0] ifg_cnt;
   logic            len_bad;

   iob_eth_rr_arb #(.NREQ(NREQ)) u_arb (
      .req (bus.req_i),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign len_bad = (bus.eng_nbytes_o < MIN_L) || (bus.eng_nbytes_o > MAX_L);

   always_ff @(posedge tx_clk_i or negedge tx_arst_n_i) begin
      if (!tx_arst_n_i) begin
         state            <= IDLE;
         ptr              <= '0;
         win_idx          <= '0;
         win_oh           <= '0;
         ifg_cnt          <= '0;
         bus.done_o       <= '0;
         bus.err_o        <= '0;
         bus.busy_o       <= 1'b0;
         bus.sel_o        <= '0;
         bus.eng_nbytes_o <= '0;
         bus.eng_send_o   <= 1'b0;
      end else begin
         bus.done_o <= '0;
         bus.err_o  <= '0;
         case (state)
            IDLE: if (arb_any) begin
               win_idx <= arb_idx;
               win_oh  <= arb_gnt;
               state   <= ARB;
            end
            ARB: begin
               bus.sel_o        <= win_idx;
               bus.eng_nbytes_o <= bus.nbytes_i[ETH_NBYTES_W*int'(win_idx) +: ETH_NBYTES_W];
               bus.busy_o       <= 1'b1;
`ifdef IOB_ETH_TX_SCHED_PRIO_EN
               if (win_idx != '0) ptr <= SELW'(rr_next(int'(win_idx), NREQ));
`else
               ptr <= SELW'(rr_next(int'(win_idx), NREQ));
`endif
               state <= CHECK;
            end
            CHECK: if (len_bad) begin
               bus.err_o  <= win_oh;
               bus.busy_o <= 1'b0;
               state      <= IDLE;
            end else if (bus.eng_ready_i) begin
               bus.eng_send_o <= 1'b1;
               state          <= SEND;
            end
            // send is a single-cycle strobe; stay here until the engine shows it took it
            SEND: begin
               bus.eng_send_o <= 1'b0;
               if (!bus.eng_ready_i) state <= WAIT_DONE;
            end
            WAIT_DONE: if (bus.eng_ready_i) begin
               bus.done_o <= win_oh;
               ifg_cnt    <= CNTW'(IFG_CYCLES - 1);
               state      <= IFG;
            end
            IFG: if (ifg_cnt == '0) begin
               bus.busy_o <= 1'b0;
               state      <= IDLE;
            end else begin
               ifg_cnt <= ifg_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_eth_tx_sched.sv
// Directed bench for iob_eth_tx_sched with a simple engine model (ready drops after send).
module tb_iob_eth_tx_sched;

`ifdef IOB_ETH_TX_SCHED_PRIO_EN
   localparam int NREQ = 3;
`else
   localparam int NREQ = 2;
`endif
   localparam int LIM = 2000;

   logic tx_clk = 1'b0;
   logic tx_arst_n = 1'b0;
   always #5 tx_clk = ~tx_clk;

   iob_eth_tx_sched_if #(.NREQ(NREQ)) bus ();

   iob_eth_tx_sched #(.NREQ(NREQ)) dut (
      .tx_clk_i    (tx_clk),
      .tx_arst_n_i (tx_arst_n),
      .bus         (bus)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   int   send_cnt = 0;
   int   eng_hold = 400;
   int   eng_cnt;
   logic eng_rdy;
   logic eng_block = 1'b0;
   logic send_q = 1'b0;
   logic inv_bad = 1'b0;

   // engine: takes send while ready, then holds ready low eng_hold cycles
   always @(posedge tx_clk or negedge tx_arst_n) begin
      if (!tx_arst_n) begin
         eng_rdy <= 1'b1;
         eng_cnt <= 0;
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) eng_rdy <= 1'b1;
      end else if (bus.eng_send_o && bus.eng_ready_i) begin
         eng_rdy <= 1'b0;
         eng_cnt <= eng_hold;
      end
   end
   assign bus.eng_ready_i = eng_rdy & ~eng_block;

   always @(posedge tx_clk) begin
      if (bus.eng_send_o) send_cnt <= send_cnt + 1;
      if ((|bus.done_o && |bus.err_o) || $countones(bus.done_o) > 1 ||
          $countones(bus.err_o) > 1 || (bus.eng_send_o && send_q))
         inv_bad <= 1'b1;
      send_q <= bus.eng_send_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge tx_clk);
   endtask

   task automatic wait_busy(input logic v, output int n);
      n = 0;
      while (bus.busy_o !== v && n < LIM) begin @(negedge tx_clk); n++; end
      chk("busy_wait_in_time", 32'(n < LIM), 1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (bus.done_o === '0 && n < LIM) begin @(negedge tx_clk); n++; end
      chk("done_wait_in_time", 32'(n < LIM), 1);
   endtask

   task automatic wait_rdy(input logic v, output int n);
      n = 0;
      while (bus.eng_ready_i !== v && n < LIM) begin @(negedge tx_clk); n++; end
      chk("ready_wait_in_time", 32'(n < LIM), 1);
   endtask

   initial begin
      int n, n0, base;
      bus.req_i    = '0;
      bus.nbytes_i = '0;
      cyc(2);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_sel", bus.sel_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_err", bus.err_o, 0);
      chk("rst_nbytes", bus.eng_nbytes_o, 0);
      chk("rst_send", bus.eng_send_o, 0);
      tx_arst_n = 1'b1;
      cyc(2);

`ifdef IOB_ETH_TX_SCHED_PRIO_EN
      begin
         int exp_sel [7] = '{0, 0, 0, 1, 2, 1, 2};
         eng_hold = 4;
         bus.nbytes_i = {11'd80, 11'd80, 11'd80};
         bus.req_i    = 3'b111;
         for (int k = 0; k < 7; k++) begin
            wait_busy(1'b1, n);
            chk("prio_sel", bus.sel_o, exp_sel[k]);
            wait_done(n);
            chk("prio_done", bus.done_o, 32'(1) << exp_sel[k]);
            if (k == 2) bus.req_i = 3'b110;
            if (k == 6) bus.req_i = 3'b000;
            wait_busy(1'b0, n);
         end
      end
`else
      // round robin with both sources held
      eng_hold = 10;
      base = send_cnt;
      bus.nbytes_i = {11'd80, 11'd80};
      bus.req_i    = 2'b11;
      n0 = 0;
      for (int k = 0; k < 4; k++) begin
         wait_busy(1'b1, n);
         if (k > 0) chk("rr_gap", n0 + n, 26);
         chk("rr_sel", bus.sel_o, k % 2);
         chk("rr_nbytes", bus.eng_nbytes_o, 80);
         wait_done(n);
         chk("rr_done", bus.done_o, (k % 2) ? 2 : 1);
         if (k == 3) bus.req_i = 2'b00;
         wait_busy(1'b0, n0);
         chk("rr_ifg", n0, 24);
      end
      chk("rr_sends", send_cnt - base, 4);

      // single frame, long engine hold
      eng_hold = 400;
      base = send_cnt;
      bus.nbytes_i[10:0] = 11'd100;
      bus.req_i = 2'b01;
      wait_busy(1'b1, n);
      chk("f1_grant_lat", n, 2);
      chk("f1_sel", bus.sel_o, 0);
      chk("f1_nbytes", bus.eng_nbytes_o, 100);
      cyc(1);
      chk("f1_send", bus.eng_send_o, 1);
      cyc(1);
      wait_rdy(1'b1, n);
      chk("f1_done_early", bus.done_o, 0);
      cyc(1);
      chk("f1_done", bus.done_o, 1);
      bus.req_i = 2'b00;
      wait_busy(1'b0, n);
      chk("f1_ifg", n, 24);
      chk("f1_sends", send_cnt - base, 1);

      // illegal lengths on source 1
      begin
         logic [10:0] bad [4] = '{11'd50, 11'd1600, 11'd71, 11'd1527};
         base = send_cnt;
         for (int k = 0; k < 4; k++) begin
            bus.nbytes_i[21:11] = bad[k];
            bus.req_i = 2'b10;
            cyc(2);
            chk("err_busy", bus.busy_o, 1);
            chk("err_sel", bus.sel_o, 1);
            cyc(1);
            chk("err_pulse", bus.err_o, 2);
            chk("err_busy_low", bus.busy_o, 0);
            chk("err_no_done", bus.done_o, 0);
            bus.req_i = 2'b00;
            cyc(1);
            chk("err_clear", bus.err_o, 0);
         end
         chk("err_no_send", send_cnt - base, 0);
      end

      // engine busy when the request arrives; minimum legal length
      eng_hold = 10;
      base = send_cnt;
      eng_block = 1'b1;
      bus.nbytes_i[10:0] = 11'd72;
      bus.req_i = 2'b01;
      cyc(2);
      chk("nr_busy", bus.busy_o, 1);
      cyc(5);
      chk("nr_hold_send", bus.eng_send_o, 0);
      chk("nr_hold_cnt", send_cnt - base, 0);
      chk("nr_no_err", bus.err_o, 0);
      eng_block = 1'b0;
      cyc(1);
      chk("nr_send", bus.eng_send_o, 1);
      cyc(1);
      chk("nr_send_drop", bus.eng_send_o, 0);
      wait_done(n);
      chk("nr_done", bus.done_o, 1);
      bus.req_i = 2'b00;
      wait_busy(1'b0, n);
      chk("nr_sends", send_cnt - base, 1);

      // reset during WAIT_DONE; pointer was 1 so source 1 is granted first
      eng_hold = 400;
      bus.nbytes_i = {11'd100, 11'd1526};
      bus.req_i = 2'b11;
      wait_busy(1'b1, n);
      chk("rst_pre_sel", bus.sel_o, 1);
      wait_rdy(1'b0, n);
      cyc(3);
      tx_arst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy_o, 0);
      chk("arst_sel", bus.sel_o, 0);
      chk("arst_nbytes", bus.eng_nbytes_o, 0);
      chk("arst_send", bus.eng_send_o, 0);
      chk("arst_done", bus.done_o, 0);
      chk("arst_err", bus.err_o, 0);
      eng_hold = 10;
      cyc(1);
      tx_arst_n = 1'b1;
      wait_busy(1'b1, n);
      chk("post_rst_sel", bus.sel_o, 0);
      chk("post_rst_nbytes", bus.eng_nbytes_o, 1526);
      wait_done(n);
      chk("post_rst_done", bus.done_o, 1);
      bus.req_i = 2'b00;
      wait_busy(1'b0, n);
`endif

      chk("pulse_invariants", inv_bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
